// File: rtl/sign_narrow_if.sv
// Valid/ready handshake bundle for the signed-narrowing stream unit.
// The slave modport is the narrowing block; master is its producer/consumer side.
interface sign_narrow_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/sign_narrow.sv
// Streaming signed narrowing IN_W -> OUT_W with saturate/wrap, overflow flag,
// 2-entry output buffer and sticky/counted overflow statistics.
module sign_narrow #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 6,
   parameter bit SAT   = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   sign_narrow_if.slave bus,
   input  logic         clr_stat,
   output logic         ovf_sticky,
   output logic [7:0]   ovf_count
);
   localparam int TW = IN_W - OUT_W + 1;

   logic [TW-1:0]    top_bits;
   logic             ovf;
   logic [OUT_W-1:0] sat_val;
   logic [OUT_W-1:0] conv;
   logic [OUT_W:0]   new_word;

   logic [OUT_W:0]   ent0_q, ent0_d;
   logic [OUT_W:0]   ent1_q, ent1_d;
   logic [1:0]       occ_q, occ_d;
   logic             sticky_q, sticky_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             push, pop;

   // Representable iff every bit from the sign down to bit OUT_W-1 agrees.
   assign top_bits = bus.in_data[IN_W-1:OUT_W-1];
   assign ovf      = ~((&top_bits) | ~(|top_bits));
   assign sat_val  = bus.in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                         : {1'b0, {(OUT_W-1){1'b1}}};
   assign conv     = (ovf && SAT) ? sat_val : bus.in_data[OUT_W-1:0];
   assign new_word = {ovf, conv};

   assign bus.in_ready  = (occ_q != 2'd2) & ~rst;
   assign bus.out_valid = (occ_q != 2'd0);
   assign bus.out_data  = ent0_q[OUT_W-1:0];
   assign bus.out_ovf   = ent0_q[OUT_W];
   assign ovf_sticky    = sticky_q;
   assign ovf_count     = cnt_q;

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   // ent0 is always the head; it keeps the last word once the buffer drains.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) ent0_d = new_word;
            else               ent1_d = new_word;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            if (occ_q == 2'd2) ent0_d = ent1_q;
            occ_d = occ_q - 2'd1;
         end
         2'b11: ent0_d = new_word;
         default: ;
      endcase
   end

   // Clear takes effect first so a same-cycle overflow still counts as one.
   always_comb begin
      sticky_d = clr_stat ? 1'b0 : sticky_q;
      cnt_d    = clr_stat ? 8'd0 : cnt_q;
      if (push && ovf) begin
         sticky_d = 1'b1;
         if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent0_q   <= '0;
         ent1_q   <= '0;
         occ_q    <= 2'd0;
         sticky_q <= 1'b0;
         cnt_q    <= 8'd0;
      end else begin
         ent0_q   <= ent0_d;
         ent1_q   <= ent1_d;
         occ_q    <= occ_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: tb/tb_sign_narrow.sv
// Randomized and directed bench for sign_narrow: a saturating and a wrapping
// instance share stimulus and are compared against a queue-based reference.
module tb_sign_narrow;
   localparam int IN_W  = 8;
   localparam int OUT_W = 6;

   logic clk;
   logic rst_r;
   logic iv;
   logic [7:0] din;
   logic ordy;
   logic clr;

   logic       stk_s, stk_w;
   logic [7:0] cnt_s, cnt_w;

   int vecs = 0;
   int errs = 0;

   logic [6:0] q_s[$];
   logic [6:0] q_w[$];
   logic [6:0] last_s, last_w;
   int         m_cnt;
   bit         m_sticky;

   sign_narrow_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifs ();
   sign_narrow_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifw ();

   assign ifs.in_valid  = iv;
   assign ifs.in_data   = din;
   assign ifs.out_ready = ordy;
   assign ifw.in_valid  = iv;
   assign ifw.in_data   = din;
   assign ifw.out_ready = ordy;

   sign_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT(1'b1)) u_sat (
      .clk(clk), .rst(rst_r), .bus(ifs), .clr_stat(clr),
      .ovf_sticky(stk_s), .ovf_count(cnt_s)
   );

   sign_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .SAT(1'b0)) u_wrap (
      .clk(clk), .rst(rst_r), .bus(ifw), .clr_stat(clr),
      .ovf_sticky(stk_w), .ovf_count(cnt_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vecs++;
      if (obs !== expv) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Reference conversion from the numeric value: {ovf, word}.
   function automatic logic [6:0] ref_word(input logic [7:0] d, input bit sat);
      int v, hi, lo, w;
      bit o;
      v  = $signed(d);
      hi = (1 << (OUT_W-1)) - 1;
      lo = -(1 << (OUT_W-1));
      o  = (v > hi) || (v < lo);
      if (o && sat) w = (v > hi) ? hi : lo;
      else          w = v;
      w = w & ((1 << OUT_W) - 1);
      return {o, w[5:0]};
   endfunction

   task automatic check_and_model();
      bit mrdy, pu, po;
      logic [6:0] hs, hw;
      mrdy = (q_s.size() < 2) && !rst_r;
      hs   = (q_s.size() != 0) ? q_s[0] : last_s;
      hw   = (q_w.size() != 0) ? q_w[0] : last_w;
      chk("in_ready_sat",  {31'd0, ifs.in_ready},  {31'd0, mrdy});
      chk("in_ready_wrap", {31'd0, ifw.in_ready},  {31'd0, mrdy});
      chk("out_valid_sat", {31'd0, ifs.out_valid}, {31'd0, q_s.size() != 0});
      chk("out_valid_wrap",{31'd0, ifw.out_valid}, {31'd0, q_w.size() != 0});
      chk("out_data_sat",  {26'd0, ifs.out_data},  {26'd0, hs[5:0]});
      chk("out_data_wrap", {26'd0, ifw.out_data},  {26'd0, hw[5:0]});
      chk("out_ovf_sat",   {31'd0, ifs.out_ovf},   {31'd0, hs[6]});
      chk("out_ovf_wrap",  {31'd0, ifw.out_ovf},   {31'd0, hw[6]});
      chk("sticky_sat",    {31'd0, stk_s}, {31'd0, m_sticky});
      chk("sticky_wrap",   {31'd0, stk_w}, {31'd0, m_sticky});
      chk("count_sat",     {24'd0, cnt_s}, m_cnt);
      chk("count_wrap",    {24'd0, cnt_w}, m_cnt);

      if (rst_r) begin
         q_s.delete();
         q_w.delete();
         last_s   = '0;
         last_w   = '0;
         m_cnt    = 0;
         m_sticky = 0;
      end else begin
         pu = iv && mrdy;
         po = (q_s.size() != 0) && ordy;
         if (clr) begin
            m_cnt    = 0;
            m_sticky = 0;
         end
         if (po) begin
            last_s = q_s.pop_front();
            last_w = q_w.pop_front();
         end
         if (pu) begin
            q_s.push_back(ref_word(din, 1'b1));
            q_w.push_back(ref_word(din, 1'b0));
            if (ref_word(din, 1'b1) & 7'h40) begin
               m_sticky = 1;
               if (m_cnt < 255) m_cnt++;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] d,
                       input logic ordy_i, input logic clr_i);
      @(posedge clk);
      #1;
      rst_r = r;
      iv    = v;
      din   = d;
      ordy  = ordy_i;
      clr   = clr_i;
      @(negedge clk);
      check_and_model();
   endtask

   initial begin
      rst_r = 1'b1; iv = 1'b0; din = '0; ordy = 1'b0; clr = 1'b0;
      last_s = '0; last_w = '0; m_cnt = 0; m_sticky = 0;

      step(1, 0, 8'h00, 0, 0);
      step(1, 0, 8'h00, 0, 0);

      // Basic conversions, including both saturation directions.
      step(0, 1, 8'h07, 1, 0);
      step(0, 1, 8'hEA, 1, 0);
      step(0, 1, 8'h2A, 1, 0);
      step(0, 1, 8'hC0, 1, 0);
      step(0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 1, 0);
      chk("count_after_two_ovf", {24'd0, cnt_s}, 32'd2);

      // Backpressure: third word waits at the producer.
      step(0, 1, 8'h01, 0, 0);
      step(0, 1, 8'h02, 0, 0);
      step(0, 1, 8'h03, 0, 0);
      step(0, 1, 8'h03, 0, 0);
      chk("bp_head_held", {26'd0, ifs.out_data}, 32'h01);
      step(0, 1, 8'h03, 1, 0);
      step(0, 1, 8'h03, 1, 0);
      step(0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 1, 0);
      step(0, 0, 8'h00, 1, 0);

      // Counter saturation, then clear racing an overflowing accept.
      for (int i = 0; i < 300; i++) step(0, 1, (i % 2) ? 8'h7F : 8'h80, 1, 0);
      step(0, 0, 8'h00, 1, 0);
      chk("count_saturated", {24'd0, cnt_s}, 32'd255);
      step(0, 1, 8'h55, 1, 1);
      step(0, 0, 8'h00, 1, 0);
      chk("clr_with_ovf_count", {24'd0, cnt_s}, 32'd1);
      chk("clr_with_ovf_sticky", {31'd0, stk_s}, 32'd1);
      step(0, 0, 8'h00, 1, 1);
      step(0, 0, 8'h00, 1, 0);
      chk("clr_alone_count", {24'd0, cnt_w}, 32'd0);

      // Reset with two words buffered.
      step(0, 1, 8'h90, 0, 0);
      step(0, 1, 8'h11, 0, 0);
      step(0, 0, 8'h00, 0, 0);
      step(1, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 1, 0);
      chk("rst_flush_valid", {31'd0, ifs.out_valid}, 32'd0);

      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 199) == 0),
              $urandom_range(0, 3) != 0,
              8'($urandom()),
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 39) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
